// File: rtl/aexm_pkg.sv
// Shared definitions for the AEXM execute-stage control logic.
package aexm_pkg;

  typedef enum logic [1:0] {
    XCTL_RST   = 2'd0,
    XCTL_RUN   = 2'd1,
    XCTL_SHIFT = 2'd2,
    XCTL_MEMW  = 2'd3
  } xctl_state_t;

  localparam logic [2:0] MXALU_BSF = 3'o5;

endpackage

// File: rtl/aexm_satcnt.sv
// 8-bit up-counter with synchronous clear and enable, saturating at all-ones.
module aexm_satcnt (
  input  logic       gclk,
  input  logic       grst_n,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] cnt
);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en && (cnt != 8'hFF)) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/aexm_xctl.sv
// Execute-stage enable sequencer: barrel-shift bubble, fetch/data stall freeze
// and a bounded data-stall timeout.
module aexm_xctl
  import aexm_pkg::*;
#(
  parameter bit         BSF = 1'b0,
  parameter logic [7:0] TMO = 8'd200
) (
  input  logic       gclk,
  input  logic       grst_n,
  input  logic [2:0] dMXALU,
  input  logic       dMEM,
  input  logic       iwait,
  input  logic       dwait,
  input  logic       tmo_clr,
  output logic       d_en,
  output logic       x_en,
  output logic [7:0] rSTALL_CNT,
  output logic       rTIMEOUT
);

  localparam logic [7:0] TMO_LAST = TMO - 8'd1;

  xctl_state_t rState;
  logic        issue;
  logic        goShift;
  logic        goMem;
  logic        tmoHit;

  // Shift takes priority over memory so an illegal shift+mem encoding stays deterministic.
  assign issue   = (rState == XCTL_RUN) && !iwait;
  assign goShift = issue && BSF && (dMXALU == MXALU_BSF);
  assign goMem   = issue && !goShift && dMEM;
  assign tmoHit  = (rState == XCTL_MEMW) && dwait && (rSTALL_CNT == TMO_LAST);

  // Enables follow iwait combinationally, so iwait must come from a register.
  assign d_en = issue;
  assign x_en = issue;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      rState   <= XCTL_RST;
      rTIMEOUT <= 1'b0;
    end else begin
      case (rState)
        XCTL_RST:   rState <= XCTL_RUN;
        XCTL_RUN: begin
          if (goShift)    rState <= XCTL_SHIFT;
          else if (goMem) rState <= XCTL_MEMW;
          else            rState <= XCTL_RUN;
        end
        XCTL_SHIFT: rState <= XCTL_RUN;
        XCTL_MEMW: begin
          if (!dwait || tmoHit) rState <= XCTL_RUN;
          else                  rState <= XCTL_MEMW;
        end
        default:    rState <= XCTL_RST;
      endcase

      if (tmoHit)       rTIMEOUT <= 1'b1;
      else if (tmo_clr) rTIMEOUT <= 1'b0;
    end
  end

  aexm_satcnt uStallCnt (
    .gclk   (gclk),
    .grst_n (grst_n),
    .clr    (goMem),
    .en     (rState == XCTL_MEMW),
    .cnt    (rSTALL_CNT)
  );

endmodule

// File: tb/tb_aexm_xctl.sv
// Scoreboard bench for aexm_xctl: dut A (shifter, TMO=5) and dut B (no shifter, default TMO).
module tb_aexm_xctl;

  logic       gclk;
  logic       grst_n;
  logic [2:0] dMXALU;
  logic       dMEM;
  logic       iwait;
  logic       dwait;
  logic       tmo_clr;

  logic       dEnA, xEnA, tmoA;
  logic [7:0] cntA;
  logic       dEnB, xEnB, tmoB;
  logic [7:0] cntB;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    int         id;
    logic       en;
    int         enB;
    logic [7:0] cnt;
    logic       tmo;
  } exp_t;

  exp_t sb[$];

  aexm_xctl #(.BSF(1'b1), .TMO(8'd5)) dutA (
    .gclk       (gclk),
    .grst_n     (grst_n),
    .dMXALU     (dMXALU),
    .dMEM       (dMEM),
    .iwait      (iwait),
    .dwait      (dwait),
    .tmo_clr    (tmo_clr),
    .d_en       (dEnA),
    .x_en       (xEnA),
    .rSTALL_CNT (cntA),
    .rTIMEOUT   (tmoA)
  );

  aexm_xctl #(.BSF(1'b0)) dutB (
    .gclk       (gclk),
    .grst_n     (grst_n),
    .dMXALU     (dMXALU),
    .dMEM       (dMEM),
    .iwait      (iwait),
    .dwait      (dwait),
    .tmo_clr    (tmo_clr),
    .d_en       (dEnB),
    .x_en       (xEnB),
    .rSTALL_CNT (cntB),
    .rTIMEOUT   (tmoB)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must show in that cycle.
  task automatic step(input int id, input logic iw, input logic [2:0] alu, input logic mem,
                      input logic dw, input logic clr, input logic en, input int enB,
                      input logic [7:0] cnt, input logic t);
    exp_t e;
    iwait   = iw;
    dMXALU  = alu;
    dMEM    = mem;
    dwait   = dw;
    tmo_clr = clr;
    e.id  = id;
    e.en  = en;
    e.enB = enB;
    e.cnt = cnt;
    e.tmo = t;
    sb.push_back(e);
    @(posedge gclk);
    #1;
  endtask

  always @(negedge gclk) begin : scoreboard
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk($sformatf("s%0d.dEnA", e.id), 32'(dEnA), 32'(e.en));
      chk($sformatf("s%0d.xEnA", e.id), 32'(xEnA), 32'(e.en));
      chk($sformatf("s%0d.cntA", e.id), 32'(cntA), 32'(e.cnt));
      chk($sformatf("s%0d.tmoA", e.id), 32'(tmoA), 32'(e.tmo));
      if (e.enB >= 0) begin
        chk($sformatf("s%0d.dEnB", e.id), 32'(dEnB), 32'(e.enB));
        chk($sformatf("s%0d.xEnB", e.id), 32'(xEnB), 32'(e.enB));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    grst_n  = 1'b0;
    dMXALU  = 3'd0;
    dMEM    = 1'b0;
    iwait   = 1'b0;
    dwait   = 1'b0;
    tmo_clr = 1'b0;
    repeat (2) @(posedge gclk);
    #1;
    chk("rst.dEnA", 32'(dEnA), 32'd0);
    chk("rst.xEnA", 32'(xEnA), 32'd0);
    chk("rst.cntA", 32'(cntA), 32'd0);
    chk("rst.tmoA", 32'(tmoA), 32'd0);
    chk("rst.dEnB", 32'(dEnB), 32'd0);
    grst_n = 1'b1;

    //   id iw alu  mem dw clr en enB cnt tmo
    step( 0, 0, 3'o0, 0, 0, 0, 0, 0, 8'd0, 0);  // RST cycle
    step( 1, 0, 3'o0, 0, 0, 0, 1, 1, 8'd0, 0);
    step( 2, 0, 3'o0, 0, 0, 0, 1, 1, 8'd0, 0);
    step( 3, 0, 3'o5, 0, 0, 0, 1, 1, 8'd0, 0);  // barrel shift issue
    step( 4, 0, 3'o0, 0, 0, 0, 0, 1, 8'd0, 0);  // bubble only with shifter
    step( 5, 0, 3'o0, 0, 0, 0, 1, 1, 8'd0, 0);
    step( 6, 1, 3'o5, 0, 0, 0, 0, 0, 8'd0, 0);  // fetch stall, no issue
    step( 7, 1, 3'o0, 1, 0, 0, 0, 0, 8'd0, 0);
    step( 8, 0, 3'o0, 0, 0, 0, 1, 1, 8'd0, 0);
    step( 9, 0, 3'o0, 1, 0, 0, 1, 1, 8'd0, 0);  // load/store issue
    step(10, 1, 3'o0, 0, 1, 0, 0, 0, 8'd0, 0);
    step(11, 0, 3'o0, 0, 1, 0, 0, 0, 8'd1, 0);
    step(12, 1, 3'o0, 0, 1, 0, 0, 0, 8'd2, 0);
    step(13, 0, 3'o0, 0, 0, 0, 0, 0, 8'd3, 0);
    step(14, 0, 3'o0, 0, 0, 0, 1, 1, 8'd4, 0);
    step(15, 0, 3'o0, 0, 0, 0, 1, 1, 8'd4, 0);
    step(16, 0, 3'o0, 1, 0, 0, 1, 1, 8'd4, 0);  // mem with no data wait
    step(17, 0, 3'o0, 0, 0, 0, 0, 0, 8'd0, 0);
    step(18, 0, 3'o0, 0, 0, 0, 1, 1, 8'd1, 0);
    step(19, 0, 3'o0, 1, 0, 0, 1, 1, 8'd1, 0);
    step(20, 0, 3'o0, 0, 1, 0, 0, 0, 8'd0, 0);
    step(21, 0, 3'o0, 0, 1, 0, 0, 0, 8'd1, 0);
    step(22, 0, 3'o0, 0, 1, 0, 0, 0, 8'd2, 0);

    // asynchronous reset in the middle of a data stall
    dwait = 1'b1;
    #1;
    chk("mid.cntA", 32'(cntA), 32'd3);
    chk("mid.cntB", 32'(cntB), 32'd3);
    grst_n = 1'b0;
    #1;
    chk("arst.dEnA", 32'(dEnA), 32'd0);
    chk("arst.xEnA", 32'(xEnA), 32'd0);
    chk("arst.cntA", 32'(cntA), 32'd0);
    chk("arst.cntB", 32'(cntB), 32'd0);
    @(posedge gclk);
    #1;
    chk("arst.hold.dEnA", 32'(dEnA), 32'd0);
    chk("arst.hold.tmoA", 32'(tmoA), 32'd0);
    grst_n = 1'b1;

    step(23, 0, 3'o0, 0, 1, 0, 0, 0, 8'd0, 0);   // RST cycle
    step(24, 0, 3'o0, 0, 1, 0, 1, 1, 8'd0, 0);
    step(25, 0, 3'o0, 1, 1, 0, 1, 1, 8'd0, 0);   // mem issue, dwait stuck
    step(26, 0, 3'o0, 0, 1, 0, 0, 0, 8'd0, 0);
    step(27, 1, 3'o0, 0, 1, 0, 0, -1, 8'd1, 0);
    step(28, 0, 3'o0, 0, 1, 0, 0, -1, 8'd2, 0);
    step(29, 0, 3'o0, 0, 1, 0, 0, -1, 8'd3, 0);
    step(30, 0, 3'o0, 0, 1, 0, 0, -1, 8'd4, 0);  // timeout cycle
    step(31, 0, 3'o0, 0, 1, 0, 1, -1, 8'd5, 1);
    step(32, 0, 3'o0, 0, 1, 1, 1, -1, 8'd5, 1);  // clear pulse
    step(33, 0, 3'o0, 0, 1, 0, 1, -1, 8'd5, 0);
    step(34, 0, 3'o0, 1, 1, 0, 1, -1, 8'd5, 0);
    step(35, 0, 3'o0, 0, 1, 0, 0, -1, 8'd0, 0);
    step(36, 0, 3'o0, 0, 1, 0, 0, -1, 8'd1, 0);
    step(37, 0, 3'o0, 0, 1, 0, 0, -1, 8'd2, 0);
    step(38, 0, 3'o0, 0, 1, 0, 0, -1, 8'd3, 0);
    step(39, 0, 3'o0, 0, 1, 1, 0, -1, 8'd4, 0);  // clear on timeout cycle
    step(40, 0, 3'o0, 0, 1, 0, 1, -1, 8'd5, 1);
    step(41, 0, 3'o0, 0, 1, 0, 1, -1, 8'd5, 1);

    @(posedge gclk);
    #1;
    chk("sbEmpty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule
